// File: rtl/vga_timing_gen.sv
// Raster timing generator and pixel output stage for an ADV7123-style VGA DAC.
// Optional macro VGA_TEST_PATTERN_EN adds an 8-bar colour pattern selected by iPatternSel.
module vga_timing_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        iClk50,
  input  logic        iReset_,
  output logic        oReq,
  output logic [9:0]  oX,
  output logic [9:0]  oY,
  input  logic [29:0] iRGB,
  input  logic        iPatternSel,
  output logic        oFrameStart,
  output logic        oVGA_CLK,
  output logic        oVGA_HS,
  output logic        oVGA_VS,
  output logic        oVGA_BLANK,
  output logic        oVGA_SYNC,
  output logic [29:0] oVGA_RGB
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(CLK_DIV / 2);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hc_q, hc_d, x_q, x_d;
  logic [VW-1:0] vc_q, vc_d, y_q, y_d;
  logic          started_q, started_d;
  logic          req_q, req_d, fs_q, fs_d, vclk_q, vclk_d;
  logic          hs_q, hs_d, vs_q, vs_d, blank_q, blank_d;
  logic [29:0]   rgb_q, rgb_d, colour;
  logic          pe;

  assign pe = (div_q == DIV_LAST);

`ifdef VGA_TEST_PATTERN_EN
  logic [2:0] bar;
  assign bar = 3'((int'(x_q) * 8) / H_ACTIVE);
  // Bar order white..black: R absent on bar bit1, G on bit2, B on bit0.
  always_comb begin
    colour = iRGB;
    if (iPatternSel) colour = {{10{~bar[1]}}, {10{~bar[2]}}, {10{~bar[0]}}};
  end
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = iPatternSel;
  assign colour = iRGB;
`endif

  // oReq/oX/oY act as a valid with no ready: upstream must have iRGB stable by the
  // pe clock that ends the requested period; there is no stall path.
  always_comb begin
    div_d     = pe ? '0 : div_q + DW'(1);
    vclk_d    = (div_d >= DIV_HALF);
    hc_d      = hc_q;
    vc_d      = vc_q;
    started_d = started_q;
    req_d     = req_q;
    x_d       = x_q;
    y_d       = y_q;
    fs_d      = 1'b0;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_d   = blank_q;
    rgb_d     = rgb_q;
    if (pe) begin
      // The first pe after reset presents (0,0) without advancing the counters.
      started_d = 1'b1;
      if (started_q) begin
        if (hc_q == H_LAST) begin
          hc_d = '0;
          vc_d = (vc_q == V_LAST) ? '0 : vc_q + VW'(1);
        end else begin
          hc_d = hc_q + HW'(1);
        end
      end
      req_d = (hc_d < H_ACT) && (vc_d < V_ACT);
      if (req_d) begin
        x_d = hc_d;
        y_d = vc_d;
      end
      fs_d    = (hc_d == '0) && (vc_d == '0);
      // Output stage reflects the period that is ending, one pixel period late.
      hs_d    = !((hc_q >= HS_BEG) && (hc_q < HS_END));
      vs_d    = !((vc_q >= VS_BEG) && (vc_q < VS_END));
      blank_d = req_q;
      rgb_d   = req_q ? colour : '0;
    end
  end

  always_ff @(posedge iClk50) begin
    if (!iReset_) begin
      div_q     <= '0;
      hc_q      <= '0;
      vc_q      <= '0;
      started_q <= 1'b0;
      req_q     <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      fs_q      <= 1'b0;
      vclk_q    <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_q   <= 1'b0;
      rgb_q     <= '0;
    end else begin
      div_q     <= div_d;
      hc_q      <= hc_d;
      vc_q      <= vc_d;
      started_q <= started_d;
      req_q     <= req_d;
      x_q       <= x_d;
      y_q       <= y_d;
      fs_q      <= fs_d;
      vclk_q    <= vclk_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_q   <= blank_d;
      rgb_q     <= rgb_d;
    end
  end

  assign oReq        = req_q;
  assign oX          = 10'(x_q);
  assign oY          = 10'(y_q);
  assign oFrameStart = fs_q;
  assign oVGA_CLK    = vclk_q;
  assign oVGA_HS     = hs_q;
  assign oVGA_VS     = vs_q;
  assign oVGA_BLANK  = blank_q;
  assign oVGA_SYNC   = 1'b0;
  assign oVGA_RGB    = rgb_q;

endmodule
